inst_word_source_arbiter: RTL and testbench
===========================================

INST_WORD_SOURCE_ARBITER -- requirements
Module: inst_word_source_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning instruction word width in bits.
REQ-002 SHALL have parameter NUM_CH, default 2, meaning number of injection channels (hazard call, interrupt, ...); legal range 1..8.
REQ-003 SHALL have parameter DEPTH, default 4, meaning per-channel injection queue entries; power of two, at least 2.
REQ-004 SHALL have parameter NOP_WORD, default 0 (WIDTH bits), meaning word driven when no valid instruction is present.
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock, rising edge active.
REQ-006 SHALL have port rst, input, 1 bit, meaning reset, asynchronous and active-high.
REQ-007 SHALL have port prog_mem_out, input, WIDTH bits, meaning word fetched from program memory.
REQ-008 SHALL have port prog_mem_valid, input, 1 bit, meaning prog_mem_out is usable this cycle.
REQ-009 SHALL have port inj_word, input, NUM_CH*WIDTH bits, meaning packed injection words, channel k at bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port inj_valid, input, NUM_CH bits, meaning per-channel push request.
REQ-011 SHALL have port inj_ready, output, NUM_CH bits, meaning per-channel queue not full.
REQ-012 SHALL have port stall, input, 1 bit, meaning downstream hold.
REQ-013 SHALL have port flush, input, 1 bit, meaning discard the output word.
REQ-014 SHALL have port instruction_word, output, WIDTH bits, meaning registered selected word.
REQ-015 SHALL have port inst_valid, output, 1 bit, meaning instruction_word is valid.
REQ-016 SHALL have port inst_src, output, SRC_W = clog2(NUM_CH+1) bits, meaning source: 0 for program memory, k+1 for channel k.
REQ-017 SHALL have port pc_hold, output, 1 bit, meaning fetch SHALL NOT advance PC (prog_mem_out not consumed this cycle).

Function
REQ-018 SHALL accept a push on channel k at a rising edge where inj_valid[k] and inj_ready[k] are both 1.
REQ-019 SHALL drive inj_ready[k] = not full(k), with no dependence on a same-cycle pop; a full queue rejects the push even if it pops that cycle.
REQ-020 SHALL make a pushed word available for selection no earlier than the cycle after acceptance (no bypass).
REQ-021 SHALL, when stall=0 and flush=0, select the lowest-index non-empty queue; pop it at the edge; load its head into instruction_word with inst_valid=1 and inst_src=k+1.
REQ-022 SHALL, when stall=0, flush=0 and all queues are empty, load prog_mem_out with inst_valid=prog_mem_valid and inst_src=0.
REQ-023 SHALL drive pc_hold combinationally = stall OR (any queue non-empty).
REQ-024 SHALL, when stall=1 and flush=0, hold all output registers and pop nothing; pushes continue.
REQ-025 SHALL, when flush=1 (flush overrides stall), load NOP_WORD, inst_valid=0, inst_src=0; pop nothing; queue contents retained.
REQ-026 SHALL preserve FIFO order within a channel; pointers wrap modulo DEPTH, with an extra bit to distinguish full from empty.
REQ-027 SHALL deliver a word accepted at edge N on instruction_word after edge N+1 at the earliest, i.e. 2-edge latency, given no higher-priority traffic and no stall.

Reset
REQ-028 SHALL, on rst=1 and independent of clk, set instruction_word=NOP_WORD, inst_valid=0, inst_src=0, and all queues empty (so inj_ready all 1 and pc_hold=stall).
REQ-029 SHALL, on reset mid-operation, discard all queued words with no partial pop or push completing.

Structure
REQ-030 SHALL keep SRC_PROG_MEM=0, the SRC_W calculation and NOP_WORD default in the shared datapath constants package/include.
REQ-031 SHALL implement each channel queue as one instance of sub-module inst_inject_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/head), generated NUM_CH times.

Verification
REQ-032 SHALL cover reset: assert rst with queues holding data -> instruction_word=0, inst_valid=0, inj_ready=2'b11 immediately, without a clock edge.
REQ-033 SHALL cover passthrough: no injections, prog_mem_out=32'h1234_5678, valid=1 -> next edge word=32'h1234_5678, inst_src=0, pc_hold=0.
REQ-034 SHALL cover priority: ch0 and ch1 push 32'hA0 and 32'hB1 on the same edge -> following edges output A0 (src=1), then B1 (src=2), then prog_mem_out; pc_hold=1 for 2 cycles.
REQ-035 SHALL cover full: push 5 words to ch0 with DEPTH=4 and stall=1 -> inj_ready[0]=0 after the 4th push, 5th word dropped; release stall -> 4 words emerge in order.
REQ-036 SHALL cover stall/flush: stall=1 with word 32'hC0DE held -> output unchanged; flush=1 with stall=1 -> word=NOP_WORD, inst_valid=0, queue count unchanged.
REQ-037 SHALL cover wrap-around: 10 push/pop cycles on ch1 with DEPTH=4 -> all 10 words out in order, with no spurious full or empty.

Source files
------------

// File: rtl/inst_word_source_arbiter_pkg.sv
// Shared datapath constants for the instruction word source arbiter:
// source encoding, source-field width and the default NOP word.
package inst_word_source_arbiter_pkg;

  localparam int SRC_PROG_MEM     = 0;
  localparam int NOP_WORD_DEFAULT = 0;

  // Source field must encode program memory plus one code per channel.
  function automatic int src_width(input int num_ch);
    return $clog2(num_ch + 1);
  endfunction

endpackage

// File: rtl/inst_inject_fifo.sv
// Per-channel injection queue: power-of-two circular buffer whose pointers
// carry one extra wrap bit so full and empty are distinguishable.
module inst_inject_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/inst_word_source_arbiter.sv
// Selects the next instruction word from injection queues (fixed priority,
// lowest channel first) or program memory, with stall hold and flush-to-NOP.
module inst_word_source_arbiter
  import inst_word_source_arbiter_pkg::*;
#(
  parameter int                WIDTH    = 32,
  parameter int                NUM_CH   = 2,
  parameter int                DEPTH    = 4,
  parameter logic [WIDTH-1:0]  NOP_WORD = WIDTH'(NOP_WORD_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WIDTH-1:0]                prog_mem_out,
  input  logic                            prog_mem_valid,
  input  logic [NUM_CH*WIDTH-1:0]         inj_word,
  input  logic [NUM_CH-1:0]               inj_valid,
  output logic [NUM_CH-1:0]               inj_ready,
  input  logic                            stall,
  input  logic                            flush,
  output logic [WIDTH-1:0]                instruction_word,
  output logic                            inst_valid,
  output logic [src_width(NUM_CH)-1:0]    inst_src,
  output logic                            pc_hold
);

  localparam int SRC_W = src_width(NUM_CH);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] sel_oh;
  logic [WIDTH-1:0]  heads [NUM_CH];
  logic [WIDTH-1:0]  sel_word;
  logic [SRC_W-1:0]  sel_src;
  logic              any_ne;
  logic              advance;

  assign inj_ready = ~full;
  assign push      = inj_valid & inj_ready;
  assign any_ne    = ~&empty;
  assign advance   = ~stall & ~flush;
  assign pc_hold   = stall | any_ne;
  assign pop       = sel_oh & {NUM_CH{advance}};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    inst_inject_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .data  (inj_word[k*WIDTH +: WIDTH]),
      .full  (full[k]),
      .empty (empty[k]),
      .head  (heads[k])
    );
  end

  // Lowest-index non-empty queue wins; program memory only when all are empty.
  always_comb begin
    logic found;
    found    = 1'b0;
    sel_oh   = '0;
    sel_word = prog_mem_out;
    sel_src  = SRC_W'(SRC_PROG_MEM);
    for (int k = 0; k < NUM_CH; k++) begin
      if (!empty[k] && !found) begin
        found     = 1'b1;
        sel_oh[k] = 1'b1;
        sel_word  = heads[k];
        sel_src   = SRC_W'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_word <= NOP_WORD;
      inst_valid       <= 1'b0;
      inst_src         <= SRC_W'(SRC_PROG_MEM);
    end else if (flush) begin
      instruction_word <= NOP_WORD;
      inst_valid       <= 1'b0;
      inst_src         <= SRC_W'(SRC_PROG_MEM);
    end else if (!stall) begin
      instruction_word <= sel_word;
      inst_valid       <= any_ne | prog_mem_valid;
      inst_src         <= sel_src;
    end
  end

endmodule

// File: tb/tb_inst_word_source_arbiter.sv
// Directed bench for inst_word_source_arbiter with WIDTH=32, NUM_CH=2, DEPTH=4.
module tb_inst_word_source_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] prog_mem_out;
  logic        prog_mem_valid;
  logic [63:0] inj_word;
  logic [1:0]  inj_valid;
  logic [1:0]  inj_ready;
  logic        stall;
  logic        flush;
  logic [31:0] instruction_word;
  logic        inst_valid;
  logic [1:0]  inst_src;
  logic        pc_hold;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_word_source_arbiter #(
    .WIDTH  (32),
    .NUM_CH (2),
    .DEPTH  (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .prog_mem_out     (prog_mem_out),
    .prog_mem_valid   (prog_mem_valid),
    .inj_word         (inj_word),
    .inj_valid        (inj_valid),
    .inj_ready        (inj_ready),
    .stall            (stall),
    .flush            (flush),
    .instruction_word (instruction_word),
    .inst_valid       (inst_valid),
    .inst_src         (inst_src),
    .pc_hold          (pc_hold)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] w, input logic v, input logic [1:0] s);
    chk({tag, ".word"},  instruction_word, w);
    chk({tag, ".valid"}, 32'(inst_valid), 32'(v));
    chk({tag, ".src"},   32'(inst_src), 32'(s));
  endtask

  initial begin
    rst            = 1'b1;
    prog_mem_out   = '0;
    prog_mem_valid = 1'b0;
    inj_word       = '0;
    inj_valid      = '0;
    stall          = 1'b0;
    flush          = 1'b0;
    #3;
    chk_out("reset", 32'h0, 1'b0, 2'd0);
    chk("reset.ready", 32'(inj_ready), 32'h3);
    tick();
    rst = 1'b0;

    // Passthrough from program memory
    prog_mem_out   = 32'h1234_5678;
    prog_mem_valid = 1'b1;
    #1;
    chk("pass.pc_hold", 32'(pc_hold), 32'h0);
    tick();
    chk_out("pass", 32'h1234_5678, 1'b1, 2'd0);

    // Same-edge pushes on both channels
    prog_mem_out = 32'hDEAD_0001;
    inj_valid    = 2'b11;
    inj_word     = {32'h0000_00B1, 32'h0000_00A0};
    tick();
    inj_valid = 2'b00;
    chk_out("prio.push_edge", 32'hDEAD_0001, 1'b1, 2'd0);
    chk("prio.pc_hold0", 32'(pc_hold), 32'h1);
    tick();
    chk_out("prio.a0", 32'h0000_00A0, 1'b1, 2'd1);
    chk("prio.pc_hold1", 32'(pc_hold), 32'h1);
    tick();
    chk_out("prio.b1", 32'h0000_00B1, 1'b1, 2'd2);
    chk("prio.pc_hold2", 32'(pc_hold), 32'h0);
    tick();
    chk_out("prio.pm", 32'hDEAD_0001, 1'b1, 2'd0);

    // Fill ch0 under stall; fifth push must be dropped
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      inj_valid = 2'b01;
      inj_word  = {32'h0, 32'hD0 + 32'(i)};
      tick();
      chk($sformatf("full.ready%0d", i), 32'(inj_ready[0]), (i < 3) ? 32'h1 : 32'h0);
    end
    inj_valid = 2'b00;
    chk_out("full.held", 32'hDEAD_0001, 1'b1, 2'd0);
    chk("full.pc_hold", 32'(pc_hold), 32'h1);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("full.out%0d", i), 32'hD0 + 32'(i), 1'b1, 2'd1);
    end
    tick();
    chk_out("full.drop", 32'hDEAD_0001, 1'b1, 2'd0);

    // Stall holds, flush overrides stall and keeps queue contents
    inj_valid = 2'b01;
    inj_word  = {32'h0, 32'h0000_C0DE};
    tick();
    inj_valid = 2'b00;
    tick();
    chk_out("sf.c0de", 32'h0000_C0DE, 1'b1, 2'd1);
    stall     = 1'b1;
    inj_valid = 2'b01;
    inj_word  = {32'h0, 32'h0000_00E1};
    tick();
    inj_valid = 2'b00;
    chk_out("sf.hold1", 32'h0000_C0DE, 1'b1, 2'd1);
    tick();
    chk_out("sf.hold2", 32'h0000_C0DE, 1'b1, 2'd1);
    flush = 1'b1;
    tick();
    chk_out("sf.flush", 32'h0, 1'b0, 2'd0);
    chk("sf.pc_hold", 32'(pc_hold), 32'h1);
    flush = 1'b0;
    stall = 1'b0;
    tick();
    chk_out("sf.retained", 32'h0000_00E1, 1'b1, 2'd1);
    chk("sf.pc_hold_after", 32'(pc_hold), 32'h0);

    // Wrap-around: continuous push/pop on ch1
    for (int i = 0; i < 10; i++) begin
      inj_valid = 2'b10;
      inj_word  = {32'h100 + 32'(i), 32'h0};
      tick();
      chk($sformatf("wrap.ready%0d", i), 32'(inj_ready[1]), 32'h1);
      if (i > 0) chk_out($sformatf("wrap.out%0d", i - 1), 32'h100 + 32'(i - 1), 1'b1, 2'd2);
    end
    inj_valid = 2'b00;
    tick();
    chk_out("wrap.out9", 32'h109, 1'b1, 2'd2);
    tick();
    chk_out("wrap.pm", 32'hDEAD_0001, 1'b1, 2'd0);

    // Asynchronous reset with data queued
    stall     = 1'b1;
    inj_valid = 2'b01;
    inj_word  = {32'h0, 32'h0000_00F0};
    tick();
    inj_valid = 2'b00;
    #2;
    rst   = 1'b1;
    stall = 1'b0;
    #1;
    chk_out("arst", 32'h0, 1'b0, 2'd0);
    chk("arst.ready", 32'(inj_ready), 32'h3);
    chk("arst.pc_hold", 32'(pc_hold), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk_out("arst.after", 32'hDEAD_0001, 1'b1, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
